logic_unit_pipe: RTL
====================

Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit; successor to the fixed 64-bit XOR logical unit in the ALU logical_units group.
- Takes two WIDTH-bit operands plus a 3-bit opcode and produces the result with zero, parity and population-count flags.
- Two-stage pipeline with valid/ready handshakes on both sides and full backpressure support.
- Sits between the ALU operand-select logic and the ALU result mux.

Parameters:
- WIDTH, 64, operand/result width in bits; legal when ≥ 2.
- TAG_W, 4, width of the sideband tag carried alongside each operation; legal when ≥ 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  unit accepts the offered operation this cycle
- in_op  input  3  opcode
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_tag  input  TAG_W  sideband tag, returned unchanged
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_result  output  WIDTH  logic result
- out_zero  output  1  out_result == 0
- out_parity  output  1  XOR-reduction of out_result
- out_popcnt  output  $clog2(WIDTH+1)  count of 1 bits in out_result
- out_tag  output  TAG_W  tag of this result

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Opcodes:
  - 000 AND: a&b
  - 001 OR: a|b
  - 010 XOR: a^b
  - 011 NOR: ~(a|b)
  - 100 XNOR: ~(a^b)
  - 101 NAND: ~(a&b)
  - 110 ANDN: a&~b
  - 111 NOTA: ~a, b ignored
- Transfers:
  - An input transfer occurs when in_valid && in_ready on a rising edge.
  - An output transfer occurs when out_valid && out_ready.
- Stage 1 (S1): registers op, a, b and tag, plus s1_valid.
- Stage 2 (S2): computes the result from S1 and registers result, zero, parity, popcnt and tag, plus s2_valid.
  - out_valid = s2_valid; all out_* signals come straight from S2 registers, with no combinational path from inputs.
- Advance rules:
  - s2_adv = s1_valid && (!s2_valid || out_ready).
  - in_ready = !rst && (!s1_valid || s2_adv).
  - in_ready has a combinational path from out_ready; this is permitted.
- Latency and throughput:
  - Latency is exactly 2 cycles: an operation accepted at edge N appears with out_valid=1 after edge N+1.
  - Throughput is 1 operation per cycle while out_ready=1.
- Stall:
  - While out_valid && !out_ready, all S2 outputs hold stable.
  - S1 holds if occupied; in_ready=0 once S1 is also full.
  - At most 2 operations are in flight. No loss, no duplication, strict FIFO order.
- Simultaneous events: in the same cycle, an output transfer, an S1→S2 move and a new input acceptance all occur together (full-pipe streaming).
- Flags:
  - out_zero, out_parity and out_popcnt always correspond to the out_result currently presented.
  - popcnt range is 0..WIDTH inclusive; for example, WIDTH=64 gives 7 bits and all-ones yields 64.
- Reset:
  - Values: s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_zero=0, out_parity=0, out_popcnt=0, out_tag=0.
  - in_ready=0 while rst=1 and 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight operations. No result for them ever appears; the first post-reset result is the first operation accepted after reset.
- Idle: S1/S2 data registers need not clear when empty; only the valids matter, except for the reset values above.
- Unknowns: X on in_a/in_b/in_op is ignored while in_valid=0.

Test Plan:
- Basic XOR, WIDTH=64:
  - Stimulus: op=010, a=AAAAAAAAAAAAAAAA, b=5555555555555555, tag=3, out_ready=1.
  - Required: after 2 cycles, result=FFFFFFFFFFFFFFFF, zero=0, parity=0, popcnt=64, tag=3.
  - Then a=b=AAAAAAAAAAAAAAAA: result=0, zero=1, parity=0, popcnt=0.
- All opcodes: a=F0F0F0F0F0F0F0F0, b=FF00FF00FF00FF00, ops 000..111 back-to-back.
  - Required results in order: F000F000F000F000, FFF0FFF0FFF0FFF0, 0FF00FF00FF00FF0, 000F000F000F000F, F00FF00FF00FF00F, 0FFF0FFF0FFF0FFF, 00F000F000F000F0, 0F0F0F0F0F0F0F0F.
  - Required: one result per cycle, consecutive cycles.
- Parity and popcount: a=0000000000000007, b=0, op=OR.
  - Required: parity=1, popcnt=3.
  - Then a=1, b=0, op=ANDN: result=1, parity=1, popcnt=1.
- Backpressure: hold out_ready=0 and offer 4 ops with tags 1..4.
  - Required: tags 1 and 2 accepted, then in_ready=0; out_valid=1 with tag 1 held stable.
  - Release out_ready: tags 1,2,3,4 emerge in order, none lost or duplicated.
- Reset mid-flight: accept 2 ops, assert rst for 1 cycle during the stall.
  - Required: out_valid=0 and all out_* = 0 the cycle after reset; the old ops never appear.
  - A new op with tag 7 emerges 2 cycles after acceptance.
- Scaled instance: WIDTH=8, TAG_W=1, op=NOR, a=00, b=00.
  - Required: result=FF, popcnt=8 (4-bit field), parity=0, zero=0.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with zero/parity/popcount flags.
// Valid/ready on both sides; S1 holds operands, S2 holds result and flags.
module logic_unit_pipe #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4,
  localparam int PW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_parity,
  output logic [PW-1:0]    out_popcnt,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOR  = 3'b011,
    OP_XNOR = 3'b100,
    OP_NAND = 3'b101,
    OP_ANDN = 3'b110,
    OP_NOTA = 3'b111
  } op_e;

  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic             s2_adv;
  logic             accept;
  logic [WIDTH-1:0] res;
  logic [PW-1:0]    cnt;

  assign s2_adv   = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !rst && (!s1_valid || s2_adv);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_AND;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_op    <= op_e'(in_op);
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_tag   <= in_tag;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    res = '0;
    unique case (s1_op)
      OP_AND:  res = s1_a & s1_b;
      OP_OR:   res = s1_a | s1_b;
      OP_XOR:  res = s1_a ^ s1_b;
      OP_NOR:  res = ~(s1_a | s1_b);
      OP_XNOR: res = ~(s1_a ^ s1_b);
      OP_NAND: res = ~(s1_a & s1_b);
      OP_ANDN: res = s1_a & ~s1_b;
      OP_NOTA: res = ~s1_a;
    endcase
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + PW'(res[i]);
    end
  end

  // Flags are registered with the result so they always match it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_parity <= 1'b0;
      out_popcnt <= '0;
      out_tag    <= '0;
    end else begin
      if (s2_adv) begin
        s2_valid   <= 1'b1;
        out_result <= res;
        out_zero   <= (res == '0);
        out_parity <= ^res;
        out_popcnt <= cnt;
        out_tag    <= s1_tag;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid;

endmodule
